seq_shifter_8b: RTL and testbench

Multi-cycle 8-bit shift/rotate engine that applies a selected one-bit operation repeatedly, once per clock, for a programmable count of 0–7. It accepts operand, mode and count through a valid/ready input handshake and returns the shifted result through a valid/ready output handshake. It sits in the Level 3 datapath library as the shift-by-N counterpart to the single-step registered shifter, for blocks that need arbitrary shift distances without a barrel shifter.

---
 rtl/shift_pkg.sv | 10 +
 rtl/shift1_8b.sv | 18 +
 rtl/seq_shifter_8b.sv | 54 +++++
 tb/tb_seq_shifter_8b.sv | 139 +++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared mode map and state encoding for the shift engines
package shift_pkg;
    localparam logic [2:0] MODE_LSR = 3'b000;
    localparam logic [2:0] MODE_LSL = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ASL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;
    localparam logic [2:0] MODE_ROL = 3'b101;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
endpackage

// File: rtl/shift1_8b.sv
// shift1_8b: combinational single-step shift/rotate operator
module shift1_8b import shift_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_next
);
    // one step of the selected operation; unused modes hold the operand
    always_comb begin
        r_next = mode == MODE_LSR ? {1'b0, r[WIDTH-1:1]} :
                 mode == MODE_LSL ? {r[WIDTH-2:0], 1'b0} :
                 mode == MODE_ASR ? {r[WIDTH-1], r[WIDTH-1:1]} :
                 mode == MODE_ASL ? {r[WIDTH-1], r[WIDTH-3:0], 1'b0} :
                 mode == MODE_ROR ? {r[0], r[WIDTH-1:1]} :
                 mode == MODE_ROL ? {r[WIDTH-2:0], r[WIDTH-1]} : r;
    end
endmodule

// File: rtl/seq_shifter_8b.sv
// seq_shifter_8b: multi-cycle shift-by-N engine with valid/ready handshakes
module seq_shifter_8b import shift_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       mode,
    input  logic [2:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
);
    state_t           state, state_n;
    logic [WIDTH-1:0] r, r_next;
    logic [2:0]       mode_q, remaining;

    shift1_8b #(.WIDTH(WIDTH)) u_step (.mode(mode_q), .r(r), .r_next(r_next));

    // next state and handshake outputs; SHIFT exits on its last step
    always_comb begin
        in_ready  = state == ST_IDLE;
        out_valid = state == ST_DONE;
        state_n   = state == ST_IDLE  ? (in_valid ? (count == 3'd0 ? ST_DONE : ST_SHIFT) : ST_IDLE) :
                    state == ST_SHIFT ? (remaining == 3'd1 ? ST_DONE : ST_SHIFT) :
                    (out_ready ? ST_IDLE : ST_DONE);
    end

    // state, working register, counter; dout loads only on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state     <= ST_IDLE;
            r         <= '0;
            mode_q    <= MODE_LSR;
            remaining <= '0;
            dout      <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && in_valid) begin
                r         <= din;
                mode_q    <= mode;
                remaining <= count;
                if (count == 3'd0) dout <= din;
            end
            if (state == ST_SHIFT) begin
                r         <= r_next;
                remaining <= remaining - 3'd1;
                if (remaining == 3'd1) dout <= r_next;
            end
        end
    end
endmodule

// File: tb/tb_seq_shifter_8b.sv
// tb_seq_shifter_8b: directed tests against a closed-form reference model
module tb_seq_shifter_8b;
    logic       clk = 0, rst_ = 0, in_valid = 0, out_ready = 0;
    logic [7:0] din = 0;
    logic [2:0] mode = 0, count = 0;
    logic       in_ready, out_valid;
    logic [7:0] dout;
    int         tests = 0, fails = 0;
    bit         chk = 0;
    bit         m_busy = 0, m_done = 0;
    int         m_wait = 0;
    logic [7:0] m_res = 0, m_dout = 0;

    seq_shifter_8b #(.WIDTH(8)) dut (
        .clk(clk), .rst_(rst_), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .mode(mode), .count(count), .out_valid(out_valid),
        .out_ready(out_ready), .dout(dout)
    );

    always #5 clk = ~clk;

    // whole-operation result from the mode definitions, not step by step
    function automatic logic [7:0] ref_op(input logic [7:0] d, input logic [2:0] m, input int n);
        logic [15:0] dd;
        dd = {d, d};
        case (m)
            3'd0: return d >> n;
            3'd1: return d << n;
            3'd2: return 8'($signed(d) >>> n);
            3'd3: return {d[7], 7'(d << n)};
            3'd4: return 8'(dd >> n);
            3'd5: return 8'(dd >> (8 - n));
            default: return d;
        endcase
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // cycle model: accept in idle, result ready count edges later, drain on out_ready
    always @(posedge clk) begin
        chk = 1;
        if (!rst_) begin
            m_busy = 0; m_done = 0; m_dout = 0;
        end else if (m_done) begin
            if (out_ready) m_done = 0;
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin m_busy = 0; m_done = 1; m_dout = m_res; end
        end else if (in_valid) begin
            m_res = ref_op(din, mode, int'(count));
            if (count == 0) begin m_done = 1; m_dout = m_res; end
            else begin m_busy = 1; m_wait = int'(count); end
        end
    end

    // compare every cycle against the model
    always @(negedge clk) begin
        if (chk) begin
            check("in_ready", int'(in_ready), int'(!(m_busy || m_done)));
            check("out_valid", int'(out_valid), int'(m_done));
            check("dout", int'(dout), int'(m_dout));
        end
    end

    task automatic run_op(input logic [7:0] d, input logic [2:0] m, input logic [2:0] c, input logic [7:0] exp);
        int n;
        @(negedge clk);
        check("accept_ready", int'(in_ready), 1);
        din = d; mode = m; count = c; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        n = 1;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("latency", n, int'(c) + 1);
        check("result", int'(dout), int'(exp));
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    initial begin
        check("model_asl", int'(ref_op(8'h96, 3'd3, 2)), 8'hD8);
        check("model_ror", int'(ref_op(8'h81, 3'd4, 4)), 8'h18);
        check("model_rol", int'(ref_op(8'h81, 3'd5, 1)), 8'h03);
        repeat (2) @(negedge clk);
        check("rst_dout", int'(dout), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        rst_ = 1;
        run_op(8'h96, 3'd0, 3'd3, 8'h12);
        run_op(8'h96, 3'd2, 3'd3, 8'hF2);
        run_op(8'h96, 3'd3, 3'd2, 8'hD8);
        run_op(8'h96, 3'd1, 3'd2, 8'h58);
        run_op(8'h81, 3'd5, 3'd1, 8'h03);
        run_op(8'h81, 3'd4, 3'd4, 8'h18);
        run_op(8'h5A, 3'd2, 3'd0, 8'h5A);
        run_op(8'h5A, 3'd7, 3'd7, 8'h5A);
        // backpressure with ignored input pulses during SHIFT and DONE
        @(negedge clk);
        din = 8'h96; mode = 3'd0; count = 3'd3; in_valid = 1;
        @(negedge clk);
        din = 8'hFF; mode = 3'd1; count = 3'd1;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            check("bp_dout", int'(dout), 8'h12);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            @(negedge clk);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("bp_drained", int'(out_valid), 0);
        run_op(8'h81, 3'd5, 3'd3, 8'h0C);
        // reset in the middle of a long rotate
        @(negedge clk);
        din = 8'hFF; mode = 3'd5; count = 3'd7; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (2) @(negedge clk);
        rst_ = 0;
        @(negedge clk);
        rst_ = 1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        run_op(8'h96, 3'd4, 3'd5, 8'hB4);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
